// File: rtl/reg_file_if.sv
// ---------------------------------------------------------------------------
// reg_file_if
//   Bundles the operand-read and writeback signals of the register file.
//
//   Signals (names match the datapath nets they carry):
//     RA, RB     read addresses for ports A and B      (master -> slave)
//     RW         write address                         (master -> slave)
//     Bus_W      write data                            (master -> slave)
//     reg_write  write enable, active high             (master -> slave)
//     Bus_A      read data for RA                      (slave  -> master)
//     Bus_B      read data for RB                      (slave  -> master)
//
//   Handshake: none. Reads are combinational and always valid; a write is
//   taken on every rising clock edge where reg_write is 1. There is no
//   valid/ready pair and no stall.
// ---------------------------------------------------------------------------
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] Bus_W;
  logic              reg_write;
  logic [DATA_W-1:0] Bus_A;
  logic [DATA_W-1:0] Bus_B;

  // Datapath / decode side drives addresses and writeback data.
  modport master (
    output RA,
    output RB,
    output RW,
    output Bus_W,
    output reg_write,
    input  Bus_A,
    input  Bus_B
  );

  // Register file side.
  modport slave (
    input  RA,
    input  RB,
    input  RW,
    input  Bus_W,
    input  reg_write,
    output Bus_A,
    output Bus_B
  );

endinterface

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   General-purpose register file: 2**ADDR_W registers of DATA_W bits.
//   Two combinational read ports (A, B) and one synchronous write port (W).
//   Register 0 always reads as zero and ignores writes.
//
//   Ports:
//     clk    system clock; writes commit on its rising edge
//     rst_n  asynchronous active-low reset; clears every register
//     bus    reg_file_if.slave (RA, RB, RW, Bus_W, reg_write, Bus_A, Bus_B)
//
//   Read/write to the same address in one cycle is not forwarded: the read
//   shows the old value until the edge, then the new one through the
//   combinational read path.
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  reg_file_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  // Next-state: copy current contents, apply the single write, then pin R0.
  always_comb begin
    regs_d = regs_q;
    if (bus.reg_write && (bus.RW != '0)) begin
      regs_d[bus.RW] = bus.Bus_W;
    end
    regs_d[0] = '0;
  end

  // Reset wins over any write in flight; release needs no extra sync stage
  // because the first edge after release simply samples regs_d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Zero-latency reads. The R0 guard is kept explicit even though regs_q[0]
  // is always zero, so the read rule does not depend on the storage detail.
  // During reset every register is already zero, so both buses read zero.
  assign bus.Bus_A = (bus.RA == '0) ? '0 : regs_q[bus.RA];
  assign bus.Bus_B = (bus.RB == '0) ? '0 : regs_q[bus.RB];

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed and randomized checks of reg_file against an array model.
// ---------------------------------------------------------------------------
module tb_reg_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  // A register file is just an array: writes land unless the target is 0
  // or reset is active; reads of address 0 give zero.
  logic [DATA_W-1:0] model_mem [NREGS];
  int total;
  int bad;

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    return model_mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) model_mem[i] = '0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_A"}, bus.Bus_A, model_read(bus.RA));
    check({tag, "_B"}, bus.Bus_B, model_read(bus.RB));
  endtask

  // ---------------- drivers ----------------
  task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic we);
    @(negedge clk);
    bus.RW        = a;
    bus.Bus_W     = d;
    bus.reg_write = we;
    @(posedge clk);
    if (rst_n && we && a != 0) model_mem[a] = d;
    #1;
    bus.reg_write = 1'b0;
  endtask

  task automatic set_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    @(negedge clk);
    bus.RA = a;
    bus.RB = b;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]        wide_addr;
    logic [ADDR_W-1:0] ra, rb, rw;
    logic [DATA_W-1:0] bw;
    logic              we;

    total = 0;
    bad   = 0;
    model_clear();
    rst_n         = 1'b0;
    bus.RA        = '0;
    bus.RB        = '0;
    bus.RW        = '0;
    bus.Bus_W     = '0;
    bus.reg_write = 1'b0;

    // Power-on reset state.
    repeat (2) @(posedge clk);
    #1;
    bus.RA = 5'd5;
    bus.RB = 5'd31;
    #1;
    check("por_a", bus.Bus_A, 32'h0);
    check("por_b", bus.Bus_B, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Mid-run asynchronous reset after R5 was written.
    drive_write(5'd5, 32'hDEADBEEF, 1'b1);
    set_read(5'd5, 5'd31);
    check("r5_written", bus.Bus_A, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;        // between edges: must clear without a clock
    model_clear();
    #1;
    check("rst_async_a", bus.Bus_A, 32'h0);
    check("rst_async_b", bus.Bus_B, 32'h0);
    // A write attempted while reset is low must be ignored.
    drive_write(5'd3, 32'hCAFEF00D, 1'b1);
    set_read(5'd3, 5'd5);
    check("rst_write_ignored", bus.Bus_A, 32'h0);
    check("rst_hold_b", bus.Bus_B, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. Basic write/read, first edge after release.
    drive_write(5'd7, 32'h000000A5, 1'b1);
    set_read(5'd7, 5'd7);
    check("basic_a", bus.Bus_A, 32'h000000A5);
    check("basic_b", bus.Bus_B, 32'h000000A5);

    // 3. Write disabled.
    drive_write(5'd7, 32'h12345678, 1'b0);
    set_read(5'd7, 5'd7);
    check("we0_hold", bus.Bus_A, 32'h000000A5);

    // 4. R0 hardwired.
    drive_write(5'd0, 32'hFFFFFFFF, 1'b1);
    set_read(5'd0, 5'd0);
    check("r0_a", bus.Bus_A, 32'h0);
    check("r0_b", bus.Bus_B, 32'h0);

    // 5. Same-cycle read/write: old value before the edge, new after.
    drive_write(5'd9, 32'h00000011, 1'b1);
    @(negedge clk);
    bus.RA        = 5'd9;
    bus.RB        = 5'd7;
    bus.RW        = 5'd9;
    bus.Bus_W     = 32'h00000022;
    bus.reg_write = 1'b1;
    #1;
    check("rw_before_edge", bus.Bus_A, 32'h00000011);
    @(posedge clk);
    model_mem[9] = 32'h00000022;
    #1;
    bus.reg_write = 1'b0;
    check("rw_after_edge", bus.Bus_A, 32'h00000022);
    check("rw_other_port", bus.Bus_B, 32'h000000A5);

    // Address truncation: a wider bench value keeps only its low bits.
    wide_addr = 8'd32;
    set_read(wide_addr[ADDR_W-1:0], 5'd9);
    check("trunc_32_is_r0", bus.Bus_A, 32'h0);
    wide_addr = 8'd39;
    set_read(wide_addr[ADDR_W-1:0], 5'd9);
    check("trunc_39_is_r7", bus.Bus_A, 32'h000000A5);

    // 6. Fill R1..R31 with index*3, sweep A up and B down.
    for (int i = 1; i < NREGS; i++) begin
      drive_write(ADDR_W'(i), DATA_W'(i * 3), 1'b1);
    end
    for (int i = 0; i < NREGS; i++) begin
      set_read(ADDR_W'(i), ADDR_W'(NREGS - 1 - i));
      check($sformatf("sweep_a_%0d", i), bus.Bus_A,
            (i == 0) ? 32'h0 : DATA_W'(i * 3));
      check($sformatf("sweep_b_%0d", NREGS - 1 - i), bus.Bus_B,
            (i == NREGS - 1) ? 32'h0 : DATA_W'((NREGS - 1 - i) * 3));
    end

    // Randomized traffic: check reads before and after every edge.
    for (int n = 0; n < 300; n++) begin
      ra = ADDR_W'($urandom_range(0, NREGS - 1));
      rb = ADDR_W'($urandom_range(0, NREGS - 1));
      rw = ($urandom_range(0, 3) == 0) ? ra : ADDR_W'($urandom_range(0, NREGS - 1));
      bw = $urandom;
      we = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      bus.RA        = ra;
      bus.RB        = rb;
      bus.RW        = rw;
      bus.Bus_W     = bw;
      bus.reg_write = we;
      #1;
      check($sformatf("rand_pre_%0d", n), bus.Bus_A, model_read(ra));
      check($sformatf("rand_pre_b_%0d", n), bus.Bus_B, model_read(rb));
      @(posedge clk);
      if (we && rw != 0) model_mem[rw] = bw;
      #1;
      check($sformatf("rand_post_%0d", n), bus.Bus_A, model_read(ra));
      check($sformatf("rand_post_b_%0d", n), bus.Bus_B, model_read(rb));
    end
    bus.reg_write = 1'b0;

    // Final full readback through both ports.
    for (int i = 0; i < NREGS; i++) begin
      set_read(ADDR_W'(i), ADDR_W'(i));
      check_ports($sformatf("final_%0d", i));
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the clock-driven sequence ever stalls.
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file for the processor datapath: 32 registers of 32 bits each.
- Two asynchronous (combinational) read ports, A and B, feed the ALU operand buses.
- One synchronous write port, W, commits writeback results on the rising clock edge when reg_write is high.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of every data bus.
- ADDR_W, 5, register address width; depth is 2**ADDR_W = 32 registers.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every register.
- RA  input  ADDR_W  read address, port A.
- RB  input  ADDR_W  read address, port B.
- RW  input  ADDR_W  write address.
- Bus_W  input  DATA_W  write data.
- reg_write  input  1  write enable, active high.
- Bus_A  output  DATA_W  read data for RA.
- Bus_B  output  DATA_W  read data for RB.

Behaviour:
- Storage: 32 x DATA_W registers, R0..R31.
- Reset:
  - rst_n low forces all registers to 0 immediately, independent of clk.
  - While rst_n is low, Bus_A = Bus_B = 0 and writes are ignored.
  - Release is synchronous-safe: the first write can occur on the first rising edge after rst_n goes high.
- Write:
  - On posedge clk with rst_n=1 and reg_write=1, R[RW] <= Bus_W.
  - If reg_write=0, no register changes.
  - A write to RW=0 is discarded; R0 always holds 0.
- Read:
  - Purely combinational, zero latency.
  - Bus_A = (RA==0) ? 0 : R[RA]; Bus_B = (RB==0) ? 0 : R[RB].
  - Outputs follow address changes within the same cycle.
- Read/write same address, same cycle:
  - There is no write-forwarding.
  - Before the edge, the read returns the old value.
  - After the edge, the read returns the newly written value. This comes from the combinational read path.
- RA and RB may be equal; both ports then return the same value.
- Address width rule: addresses are exactly ADDR_W bits, so there is no out-of-range case. Wider values driven by the bench are truncated to their low 5 bits, e.g. 32 maps to R0.
- X/Z handling: no special handling. Reg_write must be a clean 0/1 at every edge.
- Outputs are never registered. No handshake, no stall.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 mid-run after R5 was written 0xDEADBEEF.
   - Required: R5 reads 0 immediately, before any clock edge.
   - Required: RA=5 and RB=31 both give 0.
2. Basic write/read:
   - Stimulus: reg_write=1, RW=7, Bus_W=0x000000A5, one posedge; then RA=7, RB=7.
   - Required: Bus_A = Bus_B = 0x000000A5 with no added latency.
3. Write disabled:
   - Stimulus: reg_write=0, RW=7, Bus_W=0x12345678, posedge.
   - Required: R7 still reads 0x000000A5.
4. R0 hardwired:
   - Stimulus: reg_write=1, RW=0, Bus_W=0xFFFFFFFF, posedge; then RA=0.
   - Required: Bus_A = 0.
5. Same-cycle read/write:
   - Stimulus: RA=9 holding 0x11; write RW=9, Bus_W=0x22.
   - Required: Bus_A = 0x11 before the edge and 0x22 after the edge.
6. Dual-port independence:
   - Stimulus: fill R1..R31 with value = index*3; sweep RA ascending and RB descending.
   - Required: every readback matches on both ports.
